// File: rtl/uart_rx_if.sv
// Serial receive bundle for uart_rx: baud tick and line in, byte/strobe/error flags out.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            tick;
    logic            rx;
    logic [DBIT-1:0] rx_data;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;

    modport master (
        output tick, rx,
        input  rx_data, rx_done_tick, frame_err, parity_err
    );

    modport slave (
        input  tick, rx,
        output rx_data, rx_done_tick, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled asynchronous serial receiver (8N1 by default).
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic      clk_50MHz,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int            NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [3:0]    S_MID  = 4'd7;
    localparam logic [3:0]    S_LAST = 4'd15;
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic              rx_s;
    logic [3:0]        s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   data_q, data_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              brk_q, brk_d;
    logic              par_q, par_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        par_d   = par_q;
        // A frame that ended on a low line must see the line go high before re-arming.
        brk_d   = brk_q & ~rx_s;

        case (state_q)
            IDLE: begin
                if (!rx_s && !brk_q) begin
                    state_d = START;
                    s_d     = 4'd0;
                end
            end
            START: begin
                if (bus.tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            s_d     = 4'd0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.tick) begin
                    if (s_q == S_LAST) begin
                        b_d = DBIT'({rx_s, b_q} >> 1);
                        s_d = 4'd0;
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.tick) begin
                    if (s_q == S_LAST) begin
                        par_d   = rx_s;
                        s_d     = 4'd0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (bus.tick) begin
                    if (s_q == S_STOP) begin
                        data_d  = b_q;
                        ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{b_q, par_q};
`else
                        perr_d  = 1'b0;
`endif
                        done_d  = 1'b1;
                        brk_d   = ~rx_s;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            s_q     <= 4'd0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            brk_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], bus.rx};
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            brk_q   <= brk_d;
            par_q   <= par_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
    assign bus.parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; adds a parity bit to every frame when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int TDIV = 8;
    localparam int BITC = 16 * TDIV;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    logic [7:0] cap_data [0:31];
    logic       cap_ferr [0:31];
    logic       cap_perr [0:31];

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        bus.tick = 1'b0;
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.rx_done_tick) begin
            cap_data[done_cnt % 32] = bus.rx_data;
            cap_ferr[done_cnt % 32] = bus.frame_err;
            cap_perr[done_cnt % 32] = bus.parity_err;
            done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stopb, input logic parb);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(parb);
`else
        if (parb === 1'bx) bus.rx = 1'b1;
`endif
        send_bit(stopb);
    endtask

    task automatic idle(input int nbits);
        bus.rx = 1'b1;
        repeat (nbits * BITC) @(negedge clk);
    endtask

    initial begin
        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rx_data", 32'(bus.rx_data), 32'h0);
        check("reset_done", 32'(bus.rx_done_tick), 32'h0);
        check("reset_ferr", 32'(bus.frame_err), 32'h0);
        check("reset_perr", 32'(bus.parity_err), 32'h0);
        idle(2);

        // Single good frame
        send(8'h55, 1'b1, 1'b0);
        idle(2);
        check("good_count", 32'(done_cnt), 32'd1);
        check("good_data", 32'(cap_data[0]), 32'h55);
        check("good_ferr", 32'(cap_ferr[0]), 32'h0);
        check("good_perr", 32'(cap_perr[0]), 32'h0);

        // Back-to-back, no idle gap
        send(8'hA3, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        idle(2);
        check("b2b_count", 32'(done_cnt), 32'd3);
        check("b2b_data0", 32'(cap_data[1]), 32'hA3);
        check("b2b_ferr0", 32'(cap_ferr[1]), 32'h0);
        check("b2b_data1", 32'(cap_data[2]), 32'h0F);
        check("b2b_ferr1", 32'(cap_ferr[2]), 32'h0);

        // Start-bit glitch: 4 ticks low
        bus.rx = 1'b0;
        repeat (4 * TDIV) @(negedge clk);
        idle(3);
        check("glitch_count", 32'(done_cnt), 32'd3);
        check("glitch_data_held", 32'(bus.rx_data), 32'h0F);
        send(8'h81, 1'b1, 1'b0);
        idle(2);
        check("post_glitch_count", 32'(done_cnt), 32'd4);
        check("post_glitch_data", 32'(cap_data[3]), 32'h81);

        // Framing error, then recovery
        send(8'hC6, 1'b0, 1'b0);
        idle(2);
        check("ferr_count", 32'(done_cnt), 32'd5);
        check("ferr_data", 32'(cap_data[4]), 32'hC6);
        check("ferr_flag", 32'(cap_ferr[4]), 32'h1);
        check("ferr_held", 32'(bus.frame_err), 32'h1);
        send(8'h12, 1'b1, 1'b0);
        idle(2);
        check("ferr_clear_count", 32'(done_cnt), 32'd6);
        check("ferr_clear_data", 32'(cap_data[5]), 32'h12);
        check("ferr_clear_flag", 32'(cap_ferr[5]), 32'h0);

        // Break: line held low far longer than a frame
        bus.rx = 1'b0;
        repeat (30 * BITC) @(negedge clk);
        check("break_count", 32'(done_cnt), 32'd7);
        check("break_data", 32'(cap_data[6]), 32'h00);
        check("break_ferr", 32'(cap_ferr[6]), 32'h1);
        idle(2);
        check("break_no_retrigger", 32'(done_cnt), 32'd7);
        send(8'h99, 1'b1, 1'b0);
        idle(2);
        check("post_break_count", 32'(done_cnt), 32'd8);
        check("post_break_data", 32'(cap_data[7]), 32'h99);
        check("post_break_ferr", 32'(cap_ferr[7]), 32'h0);

        // Reset after the 4th data bit of 0x5A
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset  = 1'b1;
        bus.rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_data", 32'(bus.rx_data), 32'h0);
        check("rst_mid_done", 32'(bus.rx_done_tick), 32'h0);
        check("rst_mid_ferr", 32'(bus.frame_err), 32'h0);
        check("rst_mid_perr", 32'(bus.parity_err), 32'h0);
        idle(12);
        check("rst_mid_no_strobe", 32'(done_cnt), 32'd8);
        send(8'h3C, 1'b1, 1'b0);
        idle(2);
        check("rst_next_count", 32'(done_cnt), 32'd9);
        check("rst_next_data", 32'(cap_data[8]), 32'h3C);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        idle(2);
        check("par_ok_count", 32'(done_cnt), 32'd10);
        check("par_ok_perr", 32'(cap_perr[9]), 32'h0);
        send(8'h07, 1'b1, 1'b0);
        idle(2);
        check("par_bad_count", 32'(done_cnt), 32'd11);
        check("par_bad_perr", 32'(cap_perr[10]), 32'h1);
        check("par_bad_data", 32'(cap_data[10]), 32'h07);
`else
        check("noparity_perr", 32'(cap_perr[8]), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
